// File: rtl/mem_rmw_initiator_if.sv
// Bundle of the core request/response handshake and the memory read/write
// port pair seen by mem_rmw_initiator. The master modport is the initiator's
// view; the slave modport is the view of whatever drives the core side and
// models the memory.
interface mem_rmw_initiator_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_exception;
  logic [31:0] mem_read_address;
  logic [31:0] mem_read_data;
  logic        mem_read_exception;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic        mem_write_exception;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_exception,
    input  resp_ready,
    output mem_read_address,
    input  mem_read_data, mem_read_exception,
    output mem_write_enable, mem_write_address, mem_write_data,
    input  mem_write_exception
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_exception,
    output resp_ready,
    input  mem_read_address,
    output mem_read_data, mem_read_exception,
    input  mem_write_enable, mem_write_address, mem_write_data,
    output mem_write_exception
  );
endinterface

// File: rtl/mem_rmw_initiator.sv
// Load/store initiator for a word-only memory. Sub-word stores are done as
// read-modify-write; loads read the containing word and extract/extend the
// addressed lane. One request outstanding at a time.
// Optional build macro MEM_RMW_TRACE_EN: prints write strobes and responses.
//
// state | meaning
// IDLE  | ready for a request (req_ready high)
// READ  | reading the containing word, waiting READ_WAIT extra cycles
// WRITE | one-cycle full-word write strobe
// RESP  | response held until the core accepts it
module mem_rmw_initiator #(
  parameter int READ_WAIT = 0,
  parameter int CNT_W     = 4
) (
  input logic            CLK,
  input logic            RESET,
  mem_rmw_initiator_if.master bus
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(READ_WAIT);

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              write_q, write_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       word_q, word_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              exc_q, exc_d;
  logic              bad_req;

  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  sz,
                                               input logic        uns,
                                               input logic [1:0]  a);
    logic [31:0] sh_b;
    logic [31:0] sh_h;
    sh_b = word >> {a, 3'b000};
    sh_h = word >> {a[1], 4'b0000};
    case (sz)
      2'd0:    load_extract = uns ? {24'b0, sh_b[7:0]}  : {{24{sh_b[7]}}, sh_b[7:0]};
      2'd1:    load_extract = uns ? {16'b0, sh_h[15:0]} : {{16{sh_h[15]}}, sh_h[15:0]};
      default: load_extract = word;
    endcase
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wd,
                                              input logic [1:0]  sz,
                                              input logic [1:0]  a);
    logic [31:0] m;
    m = word;
    case (sz)
      2'd0:    m[{a, 3'b000} +: 8]     = wd[7:0];
      2'd1:    m[{a[1], 4'b0000} +: 16] = wd[15:0];
      default: m = wd;
    endcase
    store_merge = m;
  endfunction

  // Illegal size or misaligned address is decided at accept time, before any memory access.
  always_comb begin
    bad_req = (bus.req_size == 2'd3) ||
              (bus.req_size == 2'd1 && bus.req_addr[0]) ||
              (bus.req_size == 2'd2 && bus.req_addr[1:0] != 2'b00);
  end

  // Next-state and datapath update for the request sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    word_d  = word_q;
    rdata_d = rdata_q;
    exc_d   = exc_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          write_d = bus.req_write;
          size_d  = bus.req_size;
          uns_d   = bus.req_unsigned;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          rdata_d = 32'h0;
          exc_d   = 1'b0;
          cnt_d   = '0;
          if (bad_req) begin
            exc_d   = 1'b1;
            state_d = RESP;
          end else if (bus.req_write && bus.req_size == 2'd2) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (cnt_q == WAIT_LAST) begin
          word_d = bus.mem_read_data;
          if (!write_q) begin
            // A faulted load returns zero data alongside the exception.
            rdata_d = bus.mem_read_exception ? 32'h0
                    : load_extract(bus.mem_read_data, size_q, uns_q, addr_q[1:0]);
            exc_d   = bus.mem_read_exception;
            state_d = RESP;
          end else if (bus.mem_read_exception) begin
            exc_d   = 1'b1;
            state_d = RESP;
          end else begin
            state_d = WRITE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WRITE: begin
        exc_d   = bus.mem_write_exception;
        state_d = RESP;
      end
      RESP: begin
        if (bus.resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and request registers; reset aborts any operation in flight.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      word_q  <= 32'h0;
      rdata_q <= 32'h0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      word_q  <= word_d;
      rdata_q <= rdata_d;
      exc_q   <= exc_d;
    end
  end

  assign bus.req_ready         = (state_q == IDLE);
  assign bus.resp_valid        = (state_q == RESP);
  assign bus.resp_rdata        = rdata_q;
  assign bus.resp_exception    = exc_q;
  assign bus.mem_read_address  = {addr_q[31:2], 2'b00};
  assign bus.mem_write_address = {addr_q[31:2], 2'b00};
  // Strobe is decoded straight from the state register so reset removes it at once.
  assign bus.mem_write_enable  = (state_q == WRITE);
  assign bus.mem_write_data    = (state_q == WRITE)
                               ? store_merge(word_q, wdata_q, size_q, addr_q[1:0]) : 32'h0;

`ifdef MEM_RMW_TRACE_EN
  // Simulation trace of write strobes and response entry.
  always @(posedge CLK) begin
    if (!RESET) begin
      if (state_q == WRITE)
        $display("[MemInit] write address %h data %h", bus.mem_write_address, bus.mem_write_data);
      if (state_d == RESP && state_q != RESP)
        $display("[MemInit] resp data %h exc %b", rdata_d, exc_d);
    end
  end
`else
  // No trace output in the default build.
`endif

endmodule
